frogger_round_ctrl: RTL and testbench

Round and life controller for the Frogger game. It sits directly downstream of the frogger and car position controllers and upstream of the top-level video mux and score display. It compares the frog tile position against the three car tile positions, detects goal-row arrival, and runs the IDLE / RUNNING / HIT / SCORED / GAME_OVER state machine. From that it produces the game-active enable, a frog-reposition pulse, the score and the remaining lives.

---
 rtl/frogger_round_ctrl.sv | 130 +++++++++++++
 tb/tb_frogger_round_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/frogger_round_ctrl.sv
// Frogger round/life controller: collision and goal detection driving the IDLE/RUNNING/HIT/SCORED/GAME_OVER FSM.
// All outputs are registered, with one cycle of latency from sampled inputs. There is no backpressure; inputs are sampled every cycle.
module frogger_round_ctrl #(
    parameter int c_NUM_LIVES    = 3,
    parameter int c_SCORE_LIMIT  = 99,
    parameter int c_GOAL_ROW     = 0,
    parameter int c_PAUSE_FRAMES = 60
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_VSync,
    input  logic       i_Game_Start,
    input  logic [5:0] i_Frogger_X,
    input  logic [5:0] i_Frogger_Y,
    input  logic [5:0] i_Car_X_1,
    input  logic [5:0] i_Car_Y_1,
    input  logic [5:0] i_Car_X_2,
    input  logic [5:0] i_Car_Y_2,
    input  logic [5:0] i_Car_X_3,
    input  logic [5:0] i_Car_Y_3,
    output logic       o_Game_Active,
    output logic       o_Frogger_Reset,
    output logic [6:0] o_Score,
    output logic [3:0] o_Lives,
    output logic [2:0] o_State
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'b000,
        S_RUNNING   = 3'b001,
        S_HIT       = 3'b010,
        S_SCORED    = 3'b011,
        S_GAME_OVER = 3'b100
    } state_t;

    localparam logic [3:0] LIVES_INIT = 4'(c_NUM_LIVES);
    localparam logic [6:0] SCORE_MAX  = 7'(c_SCORE_LIMIT);
    localparam logic [5:0] GOAL_ROW   = 6'(c_GOAL_ROW);
    localparam logic [7:0] PAUSE_LAST = 8'(c_PAUSE_FRAMES - 1);

    state_t     state_q, state_d;
    logic [6:0] score_q, score_d;
    logic [3:0] lives_q, lives_d;
    logic [7:0] pause_q, pause_d;
    logic       active_q, active_d;
    logic       frog_rst_q, frog_rst_d;
    logic       start_q, vsync_q;
    logic       start_edge, frame_tick, collision, goal;

    assign start_edge = i_Game_Start & ~start_q;
    assign frame_tick = vsync_q & ~i_VSync;
    assign collision  = ((i_Frogger_X == i_Car_X_1) && (i_Frogger_Y == i_Car_Y_1)) ||
                        ((i_Frogger_X == i_Car_X_2) && (i_Frogger_Y == i_Car_Y_2)) ||
                        ((i_Frogger_X == i_Car_X_3) && (i_Frogger_Y == i_Car_Y_3));
    assign goal       = (i_Frogger_Y == GOAL_ROW);

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        lives_d    = lives_q;
        pause_d    = pause_q;
        frog_rst_d = 1'b0;
        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (start_edge) begin
                    state_d    = S_RUNNING;
                    score_d    = '0;
                    lives_d    = LIVES_INIT;
                    frog_rst_d = 1'b1;
                end
            end
            S_RUNNING: begin
                pause_d = '0;
                if (collision) begin
                    state_d = S_HIT;
                    lives_d = (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;
                end else if (goal) begin
                    state_d = S_SCORED;
                    score_d = (score_q >= SCORE_MAX) ? SCORE_MAX : score_q + 7'd1;
                end
            end
            S_HIT, S_SCORED: begin
                if (frame_tick) begin
                    if (pause_q == PAUSE_LAST) begin
                        pause_d = '0;
                        // A round ends the game when lives run out (HIT) or the score tops out (SCORED).
                        if ((state_q == S_HIT && lives_q == 4'd0) ||
                            (state_q == S_SCORED && score_q == SCORE_MAX)) begin
                            state_d = S_GAME_OVER;
                        end else begin
                            state_d    = S_RUNNING;
                            frog_rst_d = 1'b1;
                        end
                    end else begin
                        pause_d = pause_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        active_d = (state_d == S_RUNNING);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q    <= S_IDLE;
            score_q    <= '0;
            lives_q    <= LIVES_INIT;
            pause_q    <= '0;
            active_q   <= 1'b0;
            frog_rst_q <= 1'b0;
            start_q    <= 1'b1;
            vsync_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            lives_q    <= lives_d;
            pause_q    <= pause_d;
            active_q   <= active_d;
            frog_rst_q <= frog_rst_d;
            start_q    <= i_Game_Start;
            vsync_q    <= i_VSync;
        end
    end

    assign o_Game_Active   = active_q;
    assign o_Frogger_Reset = frog_rst_q;
    assign o_Score         = score_q;
    assign o_Lives         = lives_q;
    assign o_State         = state_q;
endmodule

// File: tb/tb_frogger_round_ctrl.sv
// Randomized bench for frogger_round_ctrl against a rule-level model of rounds, lives, score and pauses.
module tb_frogger_round_ctrl;
    localparam int NL = 3;
    localparam int SL = 3;
    localparam int GR = 0;
    localparam int PF = 4;

    logic       clk = 1'b0;
    logic       rst, vsync, start;
    logic [5:0] fx, fy, cx1, cy1, cx2, cy2, cx3, cy3;
    logic       act, frst;
    logic [6:0] score;
    logic [3:0] lives;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    frogger_round_ctrl #(
        .c_NUM_LIVES(NL), .c_SCORE_LIMIT(SL), .c_GOAL_ROW(GR), .c_PAUSE_FRAMES(PF)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_VSync(vsync), .i_Game_Start(start),
        .i_Frogger_X(fx), .i_Frogger_Y(fy),
        .i_Car_X_1(cx1), .i_Car_Y_1(cy1),
        .i_Car_X_2(cx2), .i_Car_Y_2(cy2),
        .i_Car_X_3(cx3), .i_Car_Y_3(cy3),
        .o_Game_Active(act), .o_Frogger_Reset(frst),
        .o_Score(score), .o_Lives(lives), .o_State(state)
    );

    always #5 clk = ~clk;

    // Model: the game phase is tracked by name, with pauses counting frames still left to wait.
    typedef enum {P_IDLE, P_PLAY, P_CRASH, P_CROSSED, P_OVER} phase_e;
    phase_e m_phase;
    int m_score, m_lives, m_wait, m_pulse;
    bit m_vs_prev, m_st_prev;

    function automatic int phase_code(phase_e p);
        case (p)
            P_IDLE:    return 0;
            P_PLAY:    return 1;
            P_CRASH:   return 2;
            P_CROSSED: return 3;
            default:   return 4;
        endcase
    endfunction

    task automatic model_step();
        bit tick, sedge, hit, at_goal;
        m_pulse = 0;
        if (rst) begin
            m_phase = P_IDLE; m_score = 0; m_lives = NL; m_wait = 0;
            m_vs_prev = 1; m_st_prev = 1;
            return;
        end
        tick    = m_vs_prev && !vsync;
        sedge   = start && !m_st_prev;
        hit     = (fx == cx1 && fy == cy1) || (fx == cx2 && fy == cy2) || (fx == cx3 && fy == cy3);
        at_goal = (int'(fy) == GR);
        case (m_phase)
            P_IDLE, P_OVER:
                if (sedge) begin
                    m_phase = P_PLAY; m_score = 0; m_lives = NL; m_pulse = 1;
                end
            P_PLAY:
                if (hit) begin
                    m_phase = P_CRASH; m_wait = PF;
                    if (m_lives > 0) m_lives--;
                end else if (at_goal) begin
                    m_phase = P_CROSSED; m_wait = PF;
                    if (m_score < SL) m_score++;
                end
            default:
                if (tick) begin
                    m_wait--;
                    if (m_wait == 0) begin
                        if ((m_phase == P_CRASH && m_lives == 0) || (m_phase == P_CROSSED && m_score == SL))
                            m_phase = P_OVER;
                        else begin
                            m_phase = P_PLAY; m_pulse = 1;
                        end
                    end
                end
        endcase
        m_vs_prev = vsync;
        m_st_prev = start;
    endtask

    task automatic chk_eq(string tag, int got, int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk_eq("state",  int'(state), phase_code(m_phase));
        chk_eq("lives",  int'(lives), m_lives);
        chk_eq("score",  int'(score), m_score);
        chk_eq("active", int'(act),   (m_phase == P_PLAY) ? 1 : 0);
        chk_eq("frst",   int'(frst),  m_pulse);
    endtask

    task automatic rand_pos();
        fx  = 6'($urandom_range(0, 3)); fy  = 6'($urandom_range(0, 5));
        cx1 = 6'($urandom_range(0, 3)); cy1 = 6'($urandom_range(0, 5));
        cx2 = 6'($urandom_range(0, 3)); cy2 = 6'($urandom_range(0, 5));
        cx3 = 6'($urandom_range(0, 3)); cy3 = 6'($urandom_range(0, 5));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b1; start = 1'b1;
        rand_pos();
        // Button held through and after reset must not start a game.
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            vsync = 1'($urandom_range(0, 1));
            step();
        end
        start = 1'b0; step();
        start = 1'b1; step();
        step();

        for (int i = 0; i < 8000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 2) == 0) vsync = ~vsync;
            if ($urandom_range(0, 24) == 0) start = ~start;
            if ($urandom_range(0, 5) == 0) rand_pos();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
